window_3x3_gen: RTL and testbench
=================================

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001: The module SHALL have parameter LINE_LEN, default 2835, meaning bytes per image row (945 pixels x 3 channels).
REQ-002: The module SHALL have parameter IMG_HEIGHT, default 630, meaning rows per frame.
REQ-003: The module SHALL have parameter PIX_STRIDE, default 3, meaning byte distance between horizontally adjacent same-channel samples.
REQ-004: Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005: Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006: Port s_axis_tvalid, input, 1 bit: input byte valid.
REQ-007: Port s_axis_tready, output, 1 bit: block accepts input byte.
REQ-008: Port s_axis_tdata, input, 8 bits: raster-order image byte.
REQ-009: Port m_axis_tvalid, output, 1 bit: window valid.
REQ-010: Port m_axis_tready, input, 1 bit: downstream accepts window.
REQ-011: Port m_axis_tdata, output, 72 bits: 3x3 window; tap k at bits [8k+7:8k], k = 3*row + col; row 0 = line r-2, col 0 = byte c-2*PIX_STRIDE; k=8 is the current byte.

Function
REQ-012: An input byte SHALL be accepted only on a cycle with s_axis_tvalid and s_axis_tready both high.
REQ-013: s_axis_tready SHALL equal m_axis_tready OR NOT m_axis_tvalid (single output register, no loss).
REQ-014: Column counter SHALL run 0..LINE_LEN-1 and row counter 0..IMG_HEIGHT-1, advancing only on acceptance; the column wraps to 0 with a row increment; the row wraps to 0 after the last byte of a frame.
REQ-015: Two line buffers of LINE_LEN bytes SHALL hold lines r-1 and r-2; each row SHALL hold a shift register of 2*PIX_STRIDE+1 bytes for taps.
REQ-016: A window SHALL be produced for an accepted byte at (r,c) only when r>=2 and c>=2*PIX_STRIDE; exactly (LINE_LEN-2*PIX_STRIDE)*(IMG_HEIGHT-2) windows per frame, no padding.
REQ-017: Latency SHALL be one cycle: the window appears on m_axis in the cycle after the accepting edge.
REQ-018: While m_axis_tvalid high and m_axis_tready low, m_axis_tdata SHALL be held stable and no internal state SHALL advance.
REQ-019: Simultaneous output handoff and input acceptance SHALL reload the output register in the same cycle (full throughput, one byte per cycle).
REQ-020: Window content SHALL never mix frames: row 0-1 of a new frame SHALL produce no windows regardless of stale line-buffer data.

Reset
REQ-021: On rst_n low at a rising edge, counters SHALL clear to 0 and m_axis_tvalid SHALL go 0; s_axis_tready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-022: Line-buffer and tap contents SHALL not be reset; reset mid-frame SHALL restart at (0,0) of a new frame.

Configuration
REQ-023: With macro WIN3X3_TLAST_EN defined, the module SHALL add output port m_axis_tlast (1 bit), high with a window whose c = LINE_LEN-1, held with tdata under stall, reset 0; without the macro the port and logic SHALL be absent.

Structure
REQ-024: A package win3x3_pkg SHALL hold WIN_W=72, DATA_W=8, the default LINE_LEN/IMG_HEIGHT/PIX_STRIDE constants, and the tap-index function.
REQ-025: One sub-module line_ram (single-port-read/write, depth LINE_LEN, 8-bit, read-before-write) SHALL implement each line buffer.

Verification (LINE_LEN=8, IMG_HEIGHT=4, PIX_STRIDE=1)
REQ-026: Ramp 0..31 continuous, m_axis_tready=1 -> 12 windows; first window on cycle after byte 18 = {18,17,16,10,9,8,2,1,0} (k8..k0); last = {31,30,29,23,22,21,15,14,13}.
REQ-027: m_axis_tready low for 3 cycles after 2nd window -> tdata stable, s_axis_tready low, output sequence identical to REQ-026.
REQ-028: s_axis_tvalid toggling 1-0 random -> identical 12 windows, in order.
REQ-029: Two back-to-back frames (ramp 0..31 then 100..131) -> 24 windows; no window during bytes 100..117; 13th window = {118,117,116,110,109,108,102,101,100}.
REQ-030: rst_n low 1 cycle after 20 bytes -> m_axis_tvalid 0 next cycle; fresh 32-byte ramp yields exactly REQ-026 results.
REQ-031: WIN3X3_TLAST_EN defined, REQ-026 stimulus -> m_axis_tlast high on windows 6 and 12 only.

Source files
------------

// File: rtl/win3x3_pkg.sv
// Shared constants and tap-index helper for the 3x3 sliding-window generator.
package win3x3_pkg;

  localparam int unsigned WIN_W          = 72;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DEF_LINE_LEN   = 2835;
  localparam int unsigned DEF_IMG_HEIGHT = 630;
  localparam int unsigned DEF_PIX_STRIDE = 3;
  localparam int unsigned WIN_ROWS       = 3;
  localparam int unsigned WIN_COLS       = 3;

  typedef logic [DATA_W-1:0] pix_t;

  // Row 0 is the oldest line, col 0 the leftmost sample; k=8 is the newest byte.
  function automatic int unsigned tap_index(input int unsigned row, input int unsigned col);
    return WIN_COLS * row + col;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of storage: combinational read of the old byte, write of the new one on the edge.
module line_ram
  import win3x3_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_LINE_LEN,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // Read-before-write: rdata shows the previous line's byte during the writing cycle.
  always_comb begin
    rdata = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding window over a raster byte stream, one byte in / one window out per cycle.
// Optional m_axis_tlast output enabled by defining WIN3X3_TLAST_EN.
module window_3x3_gen
  import win3x3_pkg::*;
#(
  parameter int unsigned LINE_LEN   = DEF_LINE_LEN,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned PIX_STRIDE = DEF_PIX_STRIDE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [7:0]       s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIN_W-1:0] m_axis_tdata
`ifdef WIN3X3_TLAST_EN
  ,
  output logic             m_axis_tlast
`endif
);

  localparam int unsigned CW     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned SR_LEN = 2 * PIX_STRIDE + 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2 * PIX_STRIDE);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          win_ok;
  logic          out_valid;
  pix_t          lb1_rd;
  pix_t          lb2_rd;
  pix_t          sr [WIN_ROWS][SR_LEN];

  always_comb begin
    s_axis_tready = rst_n & (m_axis_tready | ~out_valid);
    accept        = s_axis_tvalid & s_axis_tready;
    win_ok        = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
    m_axis_tvalid = out_valid;
  end

  // lb1 holds line r-1; lb2 is fed from lb1's outgoing byte and so holds line r-2.
  line_ram #(
    .DEPTH (LINE_LEN),
    .AW    (CW)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (s_axis_tdata),
    .rdata (lb1_rd)
  );

  line_ram #(
    .DEPTH (LINE_LEN),
    .AW    (CW)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= win_ok;
    end else if (m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  // Tap shift registers double as the output register: they only move on acceptance,
  // and acceptance implies the previous window was handed off.
  always_ff @(posedge clk) begin
    if (accept) begin
      sr[2][0] <= s_axis_tdata;
      sr[1][0] <= lb1_rd;
      sr[0][0] <= lb2_rd;
      for (int unsigned r = 0; r < WIN_ROWS; r++) begin
        for (int unsigned i = 1; i < SR_LEN; i++) begin
          sr[r][i] <= sr[r][i-1];
        end
      end
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int unsigned r = 0; r < WIN_ROWS; r++) begin
      for (int unsigned c = 0; c < WIN_COLS; c++) begin
        m_axis_tdata[DATA_W*tap_index(r, c) +: DATA_W] = sr[r][(WIN_COLS-1-c)*PIX_STRIDE];
      end
    end
  end

`ifdef WIN3X3_TLAST_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else if (accept) begin
      last_q <= win_ok && (col == COL_LAST);
    end
  end

  always_comb begin
    m_axis_tlast = last_q;
  end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen with an 8x4 image and unit stride.
module tb_window_3x3_gen;

  localparam int TL = 8;
  localparam int TH = 4;
  localparam int TP = 1;

  typedef struct {
    logic [71:0] data;
    logic        last;
  } win_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [71:0] m_axis_tdata;
`ifdef WIN3X3_TLAST_EN
  logic        m_axis_tlast;
`endif

  int total = 0;
  int passed = 0;

  win_t        exp_q [$];
  logic [71:0] log_data [$];
  logic        log_last [$];
  logic [7:0]  img [TH][TL];
  int          mrow = 0;
  int          mcol = 0;

  window_3x3_gen #(
    .LINE_LEN   (TL),
    .IMG_HEIGHT (TH),
    .PIX_STRIDE (TP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef WIN3X3_TLAST_EN
    .m_axis_tlast  (m_axis_tlast),
`endif
    .m_axis_tdata  (m_axis_tdata)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] win9(input int b8, input int b7, input int b6,
                                       input int b5, input int b4, input int b3,
                                       input int b2, input int b1, input int b0);
    return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  // Reference model: whole-image memory, window built by direct 2-D indexing.
  task automatic model_accept(input logic [7:0] d);
    win_t w;
    img[mrow][mcol] = d;
    if (mrow >= 2 && mcol >= 2*TP) begin
      w.data = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w.data[8*(3*r+c) +: 8] = img[mrow-2+r][mcol-2*TP+c*TP];
      w.last = (mcol == TL-1);
      exp_q.push_back(w);
    end
    if (mcol == TL-1) begin
      mcol = 0;
      mrow = (mrow == TH-1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic mr,
                       input logic rst, output logic acc);
    logic exp_ready;
    win_t w;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = mr;
    rst_n         = rst;
    #1;
    total++;
    if (m_axis_tvalid !== (exp_q.size() > 0))
      $display("FAIL tvalid: got %b expected %b at %0t", m_axis_tvalid, exp_q.size() > 0, $time);
    else passed++;
    if (m_axis_tvalid === 1'b1 && exp_q.size() > 0) begin
      w = exp_q[0];
      total++;
      if (m_axis_tdata !== w.data)
        $display("FAIL tdata: got %h expected %h at %0t", m_axis_tdata, w.data, $time);
      else passed++;
`ifdef WIN3X3_TLAST_EN
      total++;
      if (m_axis_tlast !== w.last)
        $display("FAIL tlast: got %b expected %b at %0t", m_axis_tlast, w.last, $time);
      else passed++;
      if (mr) log_last.push_back(m_axis_tlast);
`endif
      if (mr) begin
        void'(exp_q.pop_front());
        log_data.push_back(m_axis_tdata);
      end
    end
    exp_ready = rst && (mr || !(exp_q.size() > 0 && !mr));
    if (m_axis_tvalid === 1'b1 && !mr) exp_ready = 1'b0;
    total++;
    if (s_axis_tready !== exp_ready)
      $display("FAIL s_tready: got %b expected %b at %0t", s_axis_tready, exp_ready, $time);
    else passed++;
    acc = v && (s_axis_tready === 1'b1);
    if (acc) model_accept(d);
    if (!rst) begin
      exp_q.delete();
      mrow = 0;
      mcol = 0;
    end
    @(posedge clk);
  endtask

  task automatic send(input int n, input int mode, input bit stall,
                      input int snap_idx, output int snap);
    int   idx = 0;
    int   budget = 0;
    int   stall_left = 0;
    bit   stalled_once = 0;
    logic acc;
    logic v;
    logic mr;
    logic [7:0] d;
    snap = -1;
    while (idx < n && budget < 2000) begin
      v  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = (idx < 32) ? 8'(idx) : 8'(100 + idx - 32);
      mr = 1'b1;
      if (stall && !stalled_once && log_data.size() == 2) begin
        stall_left   = 3;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        mr = 1'b0;
        stall_left--;
      end
      cycle(v, d, mr, 1'b1, acc);
      if (acc) begin
        if (idx == snap_idx) snap = log_data.size();
        idx++;
      end
      budget++;
    end
    total++;
    if (idx < n) $display("FAIL send_budget: accepted %0d required %0d", idx, n);
    else passed++;
  endtask

  task automatic flush();
    logic acc;
    int   budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
      budget++;
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
    total++;
    if (exp_q.size() != 0) $display("FAIL flush: pending %0d required 0", exp_q.size());
    else passed++;
  endtask

  task automatic check_ramp_log(input string name);
    total++;
    if (log_data.size() != 12) $display("FAIL %s_count: got %0d expected 12", name, log_data.size());
    else passed++;
    if (log_data.size() == 12) begin
      total++;
      if (log_data[0] !== win9(18, 17, 16, 10, 9, 8, 2, 1, 0))
        $display("FAIL %s_first: got %h expected %h", name, log_data[0], win9(18, 17, 16, 10, 9, 8, 2, 1, 0));
      else passed++;
      total++;
      if (log_data[11] !== win9(31, 30, 29, 23, 22, 21, 15, 14, 13))
        $display("FAIL %s_last: got %h expected %h", name, log_data[11], win9(31, 30, 29, 23, 22, 21, 15, 14, 13));
      else passed++;
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
  endtask

  task automatic test_ramp();
    int snap;
    clear_log();
    send(32, 0, 1'b0, -1, snap);
    flush();
    check_ramp_log("ramp");
`ifdef WIN3X3_TLAST_EN
    if (log_last.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (log_last[i] !== (i == 5 || i == 11))
          $display("FAIL tlast_pos%0d: got %b expected %b", i, log_last[i], (i == 5 || i == 11));
        else passed++;
      end
    end
`endif
  endtask

  task automatic test_stall();
    int snap;
    clear_log();
    send(32, 0, 1'b1, -1, snap);
    flush();
    check_ramp_log("stall");
  endtask

  task automatic test_gaps();
    int snap;
    clear_log();
    send(32, 1, 1'b0, -1, snap);
    flush();
    check_ramp_log("gaps");
  endtask

  task automatic test_back_to_back();
    int snap;
    clear_log();
    send(64, 0, 1'b0, 50, snap);
    flush();
    total++;
    if (snap != 12) $display("FAIL b2b_no_early: got %0d windows at byte 118 expected 12", snap);
    else passed++;
    total++;
    if (log_data.size() != 24) $display("FAIL b2b_count: got %0d expected 24", log_data.size());
    else passed++;
    if (log_data.size() == 24) begin
      total++;
      if (log_data[12] !== win9(118, 117, 116, 110, 109, 108, 102, 101, 100))
        $display("FAIL b2b_13th: got %h expected %h", log_data[12],
                 win9(118, 117, 116, 110, 109, 108, 102, 101, 100));
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int   snap;
    logic acc;
    clear_log();
    send(20, 0, 1'b0, -1, snap);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, acc);
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", m_axis_tvalid);
    else passed++;
    clear_log();
    send(32, 0, 1'b0, -1, snap);
    flush();
    check_ramp_log("reset_ramp");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
